// File: rtl/hilo_mdu_sched_if.sv
// EXE-stage <-> MDU scheduler bundle: issue/operand inputs from EXE, MDU control and stall outputs.
// The exe side drives instruction info; the mdu side (scheduler) drives datapath control and stall.
interface hilo_mdu_sched_if;
    logic        EXE_Valid;
    logic [2:0]  EXE_MulDivOp;
    logic        EXE_HiLoAccess;
    logic        EXE_Flush;
    logic        Mdu_Abort;
    logic [31:0] EXE_rsData;
    logic [31:0] EXE_rtData;
    logic        Mdu_Start;
    logic        Mdu_Signed;
    logic        Mdu_IsDiv;
    logic [31:0] Mdu_OpA;
    logic [31:0] Mdu_OpB;
    logic        Mdu_HiLoWr;
    logic        Mdu_Stall;
    logic        Mdu_Busy;
    logic        Mdu_DivZero;

    modport master (
        output EXE_Valid, EXE_MulDivOp, EXE_HiLoAccess, EXE_Flush, Mdu_Abort,
               EXE_rsData, EXE_rtData,
        input  Mdu_Start, Mdu_Signed, Mdu_IsDiv, Mdu_OpA, Mdu_OpB,
               Mdu_HiLoWr, Mdu_Stall, Mdu_Busy, Mdu_DivZero
    );

    modport slave (
        input  EXE_Valid, EXE_MulDivOp, EXE_HiLoAccess, EXE_Flush, Mdu_Abort,
               EXE_rsData, EXE_rtData,
        output Mdu_Start, Mdu_Signed, Mdu_IsDiv, Mdu_OpA, Mdu_OpB,
               Mdu_HiLoWr, Mdu_Stall, Mdu_Busy, Mdu_DivZero
    );
endinterface

// File: rtl/hilo_mdu_sched.sv
// MDU issue/scoreboard: Start one cycle after accept, N BUSY cycles, HI/LO write in DONE (N+2 to free).
// Backpressure: stalls EXE only for MDU/HI-LO users while an op is in flight; one op at a time.
module hilo_mdu_sched #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    hilo_mdu_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op_vld, op_signed, op_div;
    logic             accept, div_zero, start;
    logic             start_q, signed_q, isdiv_q, divzero_q;
    logic [31:0]      opa_q, opb_q;

    always_comb begin
        op_vld    = (bus.EXE_MulDivOp >= 3'd1) && (bus.EXE_MulDivOp <= 3'd4);
        op_signed = (bus.EXE_MulDivOp == 3'd1) || (bus.EXE_MulDivOp == 3'd3);
        op_div    = (bus.EXE_MulDivOp == 3'd3) || (bus.EXE_MulDivOp == 3'd4);
    end

    assign accept   = (state == IDLE) && bus.EXE_Valid && op_vld && !bus.EXE_Flush;
    // A divide by zero is dropped at issue: no datapath start, HI/LO untouched.
    assign div_zero = accept && op_div && (bus.EXE_rtData == 32'd0);
    assign start    = accept && !div_zero;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = op_div ? DIV_LD : MUL_LD;
                end
            end
            BUSY: begin
                if (bus.Mdu_Abort) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            start_q   <= 1'b0;
            signed_q  <= 1'b0;
            isdiv_q   <= 1'b0;
            divzero_q <= 1'b0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            start_q   <= start;
            divzero_q <= div_zero;
            if (start) begin
                signed_q <= op_signed;
                isdiv_q  <= op_div;
                opa_q    <= bus.EXE_rsData;
                opb_q    <= bus.EXE_rtData;
            end
        end
    end

    assign bus.Mdu_Start   = start_q;
    assign bus.Mdu_Signed  = signed_q;
    assign bus.Mdu_IsDiv   = isdiv_q;
    assign bus.Mdu_OpA     = opa_q;
    assign bus.Mdu_OpB     = opb_q;
    assign bus.Mdu_DivZero = divzero_q;
    assign bus.Mdu_HiLoWr  = (state == DONE) && !bus.Mdu_Abort;
    assign bus.Mdu_Busy    = (state != IDLE);
    assign bus.Mdu_Stall   = bus.EXE_Valid && !bus.EXE_Flush &&
                             (op_vld || bus.EXE_HiLoAccess) && (state != IDLE);
endmodule

// File: tb/tb_hilo_mdu_sched.sv
// Directed bench for hilo_mdu_sched: hand-computed cycle expectations, immediate assertions.
module tb_hilo_mdu_sched;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hilo_mdu_sched_if bus();

    hilo_mdu_sched #(.MUL_CYCLES(2), .DIV_CYCLES(33)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic hl, input logic fl,
                         input logic ab, input logic [31:0] a, input logic [31:0] b);
        bus.EXE_Valid      = v;
        bus.EXE_MulDivOp   = op;
        bus.EXE_HiLoAccess = hl;
        bus.EXE_Flush      = fl;
        bus.Mdu_Abort      = ab;
        bus.EXE_rsData     = a;
        bus.EXE_rtData     = b;
        #1;
    endtask

    // Advance to the next cycle; inputs change 1 time unit after the rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int stall_n, hw_n, hw_at, start_n, busy_n;

        idle();
        #2;
        chk("rst_start", bus.Mdu_Start, 0);
        chk("rst_busy", bus.Mdu_Busy, 0);
        chk("rst_hilowr", bus.Mdu_HiLoWr, 0);
        chk("rst_opa", bus.Mdu_OpA, 0);
        chk("rst_divzero", bus.Mdu_DivZero, 0);
        next(); next();
        resetn = 1'b1;
        next();

        // MULT 6*7
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'd6, 32'd7);
        chk("mul_c0_busy", bus.Mdu_Busy, 0);
        chk("mul_c0_stall", bus.Mdu_Stall, 0);
        next(); idle();
        chk("mul_c1_start", bus.Mdu_Start, 1);
        chk("mul_c1_opa", bus.Mdu_OpA, 6);
        chk("mul_c1_opb", bus.Mdu_OpB, 7);
        chk("mul_c1_signed", bus.Mdu_Signed, 1);
        chk("mul_c1_isdiv", bus.Mdu_IsDiv, 0);
        chk("mul_c1_busy", bus.Mdu_Busy, 1);
        chk("mul_c1_hilowr", bus.Mdu_HiLoWr, 0);
        next(); idle();
        chk("mul_c2_start", bus.Mdu_Start, 0);
        chk("mul_c2_hilowr", bus.Mdu_HiLoWr, 0);
        next(); idle();
        chk("mul_c3_hilowr", bus.Mdu_HiLoWr, 1);
        next(); idle();
        chk("mul_c4_busy", bus.Mdu_Busy, 0);
        chk("mul_c4_hilowr", bus.Mdu_HiLoWr, 0);
        next();

        // DIVU with MFHI waiting behind it
        drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
        next();
        stall_n = 0; hw_at = -1;
        for (int k = 1; k <= 35; k++) begin
            drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            if (bus.Mdu_Stall) stall_n++;
            if (bus.Mdu_HiLoWr) hw_at = k;
            if (k == 1) begin
                chk("divu_isdiv", bus.Mdu_IsDiv, 1);
                chk("divu_signed", bus.Mdu_Signed, 0);
            end
            if (k == 35) chk("divu_c35_stall", bus.Mdu_Stall, 0);
            next();
        end
        chk("divu_stall_cycles", stall_n, 34);
        chk("divu_hilowr_cycle", hw_at, 34);
        idle();
        next();

        // DIV by zero
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
        next(); idle();
        chk("dz_divzero", bus.Mdu_DivZero, 1);
        chk("dz_start", bus.Mdu_Start, 0);
        chk("dz_busy", bus.Mdu_Busy, 0);
        hw_n = 0; busy_n = 0;
        for (int k = 0; k < 5; k++) begin
            next(); idle();
            if (bus.Mdu_HiLoWr) hw_n++;
            if (bus.Mdu_Busy) busy_n++;
        end
        chk("dz_divzero_clear", bus.Mdu_DivZero, 0);
        chk("dz_hilowr_never", hw_n, 0);
        chk("dz_busy_never", busy_n, 0);
        next();

        // MULTU aborted in BUSY
        drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        next(); idle();
        chk("abb_c1_busy", bus.Mdu_Busy, 1);
        next();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        next(); idle();
        chk("abb_c3_busy", bus.Mdu_Busy, 0);
        chk("abb_c3_hilowr", bus.Mdu_HiLoWr, 0);
        next(); idle();
        chk("abb_c4_hilowr", bus.Mdu_HiLoWr, 0);
        next();

        // MULT aborted in DONE
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        next(); idle();
        next(); idle();
        next();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        chk("abd_c3_busy", bus.Mdu_Busy, 1);
        chk("abd_c3_hilowr", bus.Mdu_HiLoWr, 0);
        next(); idle();
        chk("abd_c4_busy", bus.Mdu_Busy, 0);
        next();

        // DIV in flight, MULT waits from cycle 5
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFEC, 32'd3);
        next();
        for (int k = 1; k <= 4; k++) begin
            idle();
            next();
        end
        stall_n = 0; start_n = 0;
        for (int k = 5; k <= 35; k++) begin
            drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3);
            if (bus.Mdu_Stall) stall_n++;
            if (bus.Mdu_Start) start_n++;
            if (k == 34) chk("dep_c34_hilowr", bus.Mdu_HiLoWr, 1);
            if (k == 35) chk("dep_c35_stall", bus.Mdu_Stall, 0);
            next();
        end
        idle();
        chk("dep_stall_cycles", stall_n, 30);
        chk("dep_no_early_start", start_n, 0);
        chk("dep_c36_start", bus.Mdu_Start, 1);
        chk("dep_c36_opa", bus.Mdu_OpA, 2);
        chk("dep_c36_isdiv", bus.Mdu_IsDiv, 0);
        for (int k = 0; k < 4; k++) begin
            next(); idle();
        end
        chk("dep_c40_busy", bus.Mdu_Busy, 0);
        next();

        // Same, but the arriving MULT is flushed
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'd50, 32'd5);
        next();
        for (int k = 1; k <= 4; k++) begin
            idle();
            next();
        end
        stall_n = 0;
        for (int k = 5; k <= 35; k++) begin
            drive(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'd9, 32'd9);
            if (bus.Mdu_Stall) stall_n++;
            next();
        end
        idle();
        chk("fl_stall_cycles", stall_n, 0);
        chk("fl_c36_start", bus.Mdu_Start, 0);
        chk("fl_c36_busy", bus.Mdu_Busy, 0);
        next();

        // Reset in the middle of a DIV
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'd77, 32'd11);
        next();
        for (int k = 1; k < 10; k++) begin
            idle();
            next();
        end
        idle();
        chk("rm_c10_busy", bus.Mdu_Busy, 1);
        resetn = 1'b0;
        #1;
        chk("rm_busy", bus.Mdu_Busy, 0);
        chk("rm_opa", bus.Mdu_OpA, 0);
        chk("rm_opb", bus.Mdu_OpB, 0);
        chk("rm_isdiv", bus.Mdu_IsDiv, 0);
        chk("rm_signed", bus.Mdu_Signed, 0);
        chk("rm_hilowr", bus.Mdu_HiLoWr, 0);
        next();
        resetn = 1'b1;
        hw_n = 0; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            next(); idle();
            if (bus.Mdu_HiLoWr) hw_n++;
            if (bus.Mdu_Busy) busy_n++;
        end
        chk("rm_no_hilowr", hw_n, 0);
        chk("rm_no_busy", busy_n, 0);
        next();
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'd12, 32'd13);
        next(); idle();
        chk("rm_new_start", bus.Mdu_Start, 1);
        chk("rm_new_opb", bus.Mdu_OpB, 13);
        next(); idle();
        next(); idle();
        chk("rm_new_hilowr", bus.Mdu_HiLoWr, 1);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_mdu_sched.md
Name: hilo_mdu_sched

Overview:
- Issue/scoreboard controller for the multi-cycle multiply/divide unit (MDU) and the HI/LO register pair in the EXE stage.
- Accepts MULT/MULTU/DIV/DIVU from EXE, latches operands and drives the MDU datapath start/mode. Counts fixed latency, then pulses the HI/LO write enable.
- Stalls EXE only when a later instruction needs HI/LO or the MDU while an operation is in flight. Issue is non-blocking: the MDU instruction itself leaves EXE immediately.

Parameters:
- MUL_CYCLES, 2, BUSY cycles for MULT/MULTU (legal range 1..DIV_CYCLES).
- DIV_CYCLES, 33, BUSY cycles for DIV/DIVU.
- CNT_W, $clog2(DIV_CYCLES+1), latency counter width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- EXE_Valid  in  1  EXE holds a valid instruction.
- EXE_MulDivOp  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU; other codes treated as none.
- EXE_HiLoAccess  in  1  EXE instruction reads or writes HI/LO (MFHI/MFLO/MTHI/MTLO).
- EXE_Flush  in  1  EXE instruction is being killed this cycle.
- Mdu_Abort  in  1  exception kills the in-flight MDU instruction.
- EXE_rsData  in  32  operand A.
- EXE_rtData  in  32  operand B.
- Mdu_Start  out  1  one-cycle start pulse to the MDU datapath.
- Mdu_Signed  out  1  1 for MULT/DIV.
- Mdu_IsDiv  out  1  1 for DIV/DIVU.
- Mdu_OpA  out  32  latched operand A.
- Mdu_OpB  out  32  latched operand B.
- Mdu_HiLoWr  out  1  HI and LO write enable, one cycle.
- Mdu_Stall  out  1  freeze IF/ID/EXE.
- Mdu_Busy  out  1  state != IDLE.
- Mdu_DivZero  out  1  one-cycle pulse when a divide by zero is dropped.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (resetn=0, asynchronous): state=IDLE, counter=0. Mdu_Start, Mdu_Signed, Mdu_IsDiv, Mdu_DivZero=0; Mdu_OpA/Mdu_OpB=0. All other outputs 0 through the combinational rules.
- Reset mid-operation abandons the operation; no Mdu_HiLoWr is issued.
- Accept condition (cycle T): state==IDLE && EXE_Valid && op!=none && !EXE_Flush.
  - At the T+1 edge: latch operands, Signed, IsDiv; Mdu_Start=1 for cycle T+1 only; counter=N-1 (N=MUL_CYCLES or DIV_CYCLES); state=BUSY.
- Divide by zero: DIV/DIVU with EXE_rtData==0 at accept.
  - No Start; state stays IDLE; Mdu_DivZero=1 in cycle T+1.
  - HI/LO are left unchanged (team decision).
- BUSY: counter==0 -> DONE; otherwise decrement. BUSY lasts exactly N cycles (T+1..T+N).
- DONE: one cycle (T+N+1), then IDLE.
  - Mdu_HiLoWr = (state==DONE) && !Mdu_Abort, combinational.
  - HI/LO are updated at the end of DONE.
- Mdu_Abort: in BUSY, next state=IDLE with no write. In DONE, write suppressed. In IDLE, ignored.
- Mdu_Stall = EXE_Valid && !EXE_Flush && (op!=none || EXE_HiLoAccess) && state!=IDLE.
  - A dependent instruction is stalled through DONE and proceeds at T+N+2.
  - A stalled MDU op is accepted in the first IDLE cycle.
- Mdu_Busy = state!=IDLE.
- No back-to-back overlap: at most one operation in flight.

Test Plan:
- MULT rs=6, rt=7 accepted at cycle 0 -> Start=1 at cycle 1, OpA=6, OpB=7, Signed=1, IsDiv=0. BUSY cycles 1-2, HiLoWr=1 only at cycle 3, Busy=0 at cycle 4.
- DIVU accepted at 0, MFHI in EXE from cycle 1 -> Stall=1 cycles 1-34, HiLoWr at 34, Stall=0 at 35.
- DIV with rt=0 -> no Start, DivZero=1 at cycle 1, Busy stays 0, HiLoWr never asserted.
- MULTU accepted, Mdu_Abort=1 at cycle 2 -> state IDLE at cycle 3, no HiLoWr. Separately, Abort during DONE -> HiLoWr=0 that cycle.
- DIV in flight, MULT arrives in EXE at cycle 5 -> Stall=1 until DONE (cycle 34), MULT accepted at 35, Start at 36. With EXE_Flush=1 on the arriving op -> Stall=0, no accept.
- resetn=0 asserted at cycle 10 of a DIV -> all outputs 0 immediately. After release, no HiLoWr; a new MULT is accepted normally.
